rr_mux_arbiter: RTL

Round-robin arbiter that shares one 4:1 data multiplexer among four requesters. It grants one requester at a time and drives the mux select from the grant. It forces rotation after MAX_HOLD cycles when other requesters are waiting. It sits in front of any shared single-consumer resource fed by four sources.

---
 rtl/rr_mux_arbiter_pkg.sv | 45 ++++
 rtl/rr_mux_arbiter_pick4.sv | 34 +++
 rtl/rr_mux_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// Shared constants and helpers for the four-way round-robin mux arbiter.
// Covers request count, index widths, FSM encoding and one-hot conversions.
package rr_mux_arbiter_pkg;

  localparam int N_REQ  = 4;
  localparam int SEL_W  = 2;
  localparam int HOLD_W = 4;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [N_REQ-1:0] OH_0 = 4'b0001;
  localparam logic [N_REQ-1:0] OH_1 = 4'b0010;
  localparam logic [N_REQ-1:0] OH_2 = 4'b0100;
  localparam logic [N_REQ-1:0] OH_3 = 4'b1000;

  function automatic logic [N_REQ-1:0] idx2oh(
    input logic [SEL_W-1:0] idx
  );
    logic [N_REQ-1:0] oh;
    oh = '0;
    unique case (idx)
      2'd0:    oh = OH_0;
      2'd1:    oh = OH_1;
      2'd2:    oh = OH_2;
      default: oh = OH_3;
    endcase
    return oh;
  endfunction

  function automatic logic [SEL_W-1:0] oh2idx(
    input logic [N_REQ-1:0] oh
  );
    logic [SEL_W-1:0] idx;
    idx = '0;
    unique case (oh)
      OH_1:    idx = 2'd1;
      OH_2:    idx = 2'd2;
      OH_3:    idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick4.sv
// Cyclic first-set-bit finder over four requests.
// The search begins at start and wraps modulo four.
module rr_pick4
  import rr_mux_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  assign dbl = {req, req};
  assign rot = dbl[start +: N_REQ];
  assign any = |req;

  // rot[0] is req[start], so the lowest set bit is the next in turn
  always_comb begin
    off = '0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
  end

  assign win = start + off;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter that owns a 4:1 data mux for four requesters.
// A holder is forced off after MAX_HOLD cycles if anyone else is waiting.
module rr_mux_arbiter
  import rr_mux_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] din,
  output logic [N_REQ-1:0]       gnt,
  output logic [SEL_W-1:0]       sel,
  output logic [WIDTH-1:0]       dout,
  output logic                   dout_valid,
  output logic                   busy
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

  logic [0:0]        state;
  logic [0:0]        nxt_state;
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  nxt_ptr;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] nxt_cnt;
  logic [N_REQ-1:0]  nxt_gnt;
  logic [SEL_W-1:0]  nxt_sel;

  logic [SEL_W-1:0]  start;
  logic              pick_any;
  logic [SEL_W-1:0]  pick_win;
  logic [N_REQ-1:0]  others;
  logic              holding;
  logic              at_max;
  logic              handover;

  assign start = (state == ST_GRANT) ? sel + 2'd1 : ptr;

  rr_pick4 u_pick (
    .req   (req),
    .start (start),
    .any   (pick_any),
    .win   (pick_win)
  );

  assign others  = req & ~gnt;
  assign holding = |(req & gnt);
  assign at_max  = (hold_cnt == HOLD_MAX);

  // Release with waiters and forced rotation share one handover path
  always_comb begin
    handover = 1'b0;
    if (state == ST_IDLE)
      handover = pick_any;
    else if (!holding)
      handover = |others;
    else if (at_max)
      handover = |others;
  end

  always_comb begin
    nxt_state = state;
    nxt_gnt   = gnt;
    nxt_sel   = sel;
    nxt_ptr   = ptr;
    nxt_cnt   = hold_cnt;
    if (handover) begin
      nxt_state = ST_GRANT;
      nxt_gnt   = idx2oh(pick_win);
      nxt_sel   = pick_win;
      nxt_ptr   = pick_win + 2'd1;
      nxt_cnt   = 4'd1;
    end else if (state == ST_GRANT) begin
      if (!holding) begin
        nxt_state = ST_IDLE;
        nxt_gnt   = '0;
        nxt_sel   = '0;
        nxt_ptr   = sel + 2'd1;
        nxt_cnt   = '0;
      end else if (!at_max) begin
        nxt_cnt = hold_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      sel      <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= nxt_state;
      gnt      <= nxt_gnt;
      sel      <= nxt_sel;
      ptr      <= nxt_ptr;
      hold_cnt <= nxt_cnt;
    end
  end

  assign dout_valid = |gnt;
  assign busy       = (state == ST_GRANT);

  always_comb begin
    dout = '0;
    if (dout_valid) begin
      unique case (sel)
        2'd0:    dout = din[0*WIDTH +: WIDTH];
        2'd1:    dout = din[1*WIDTH +: WIDTH];
        2'd2:    dout = din[2*WIDTH +: WIDTH];
        default: dout = din[3*WIDTH +: WIDTH];
      endcase
    end
  end

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(gnt)
  );

  a_sel_match: assert property (
    @(posedge clk) disable iff (!rst_n)
      (gnt == '0) || (gnt == idx2oh(sel))
  );

endmodule
